keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad on one system clock. Uses the ~1 kHz square wave from the clock divider as a scan-rate enable, never as a clock. Drives one column low at a time, debounces presses and releases, and delivers one key code per press through a valid/ack handshake to the downstream display/controller logic.

---
 rtl/keypad_scanner_pkg.sv | 27 ++
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner_sync_edge.sv | 29 ++
 rtl/keypad_scanner.sv | 129 ++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types, sizes and small decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  // Column index to active-low drive pattern: exactly one bit low.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Lowest-index row that reads low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] rows_n);
    lowest_row = 2'd3;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!rows_n[r]) lowest_row = 2'(r);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key delivery handshake between the scanner (master) and its consumer (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             overrun;
  logic             key_ack;

  modport master (output key_code, output key_valid, output overrun, input key_ack);
  modport slave  (input key_code, input key_valid, input overrun, output key_ack);
endinterface

// File: rtl/keypad_scanner_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q, pulse_q;

  // NOTE: every flop here uses <= so all stages shift together on one edge;
  // blocking assignments would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: tick-paced column scan, press/release debounce, one key per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_tick_i,
  input  logic [NUM_ROWS-1:0] rows_i,
  output logic [NUM_COLS-1:0] cols_o,
  keypad_scanner_if.master    key_if
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

  logic                tick;
  logic [NUM_ROWS-1:0] rows_meta_q, rows_s_q;

  state_e              state_q;
  logic [1:0]          col_q, row_q;
  logic [3:0]          cnt_q;
  logic [NUM_COLS-1:0] cols_q;
  logic [KEY_W-1:0]    code_q;
  logic                valid_q, overrun_q;

  sync_edge u_tick_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (scan_tick_i),
    .pulse_o (tick)
  );

  // NOTE: synchronizer resets to all-ones so no row looks pressed coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q <= '1;
      rows_s_q    <= '1;
    end else begin
      rows_meta_q <= rows_i;
      rows_s_q    <= rows_meta_q;
    end
  end

  logic       any_pressed, row_pressed, cnt_done, accept;
  logic [1:0] low_row, accept_row, col_next;
  logic [3:0] cnt_inc;

  assign any_pressed = ~&rows_s_q;
  assign low_row     = lowest_row(rows_s_q);
  assign row_pressed = ~rows_s_q[row_q];
  assign cnt_inc     = cnt_q + 4'd1;
  assign cnt_done    = (cnt_inc == DB_LIMIT);
  assign col_next    = col_q + 2'd1;
  assign accept_row  = (state_q == SCAN) ? low_row : row_q;
  assign accept      = tick && (((state_q == SCAN) && any_pressed && (DB_LIMIT == 4'd1)) ||
                                ((state_q == DEBOUNCE) && row_pressed && cnt_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= 4'd0;
      cols_q  <= col_drive(2'd0);
    end else if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (any_pressed) begin
            row_q   <= low_row;
            cnt_q   <= (DB_LIMIT == 4'd1) ? 4'd0 : 4'd1;
            state_q <= (DB_LIMIT == 4'd1) ? HELD : DEBOUNCE;
          end else begin
            col_q  <= col_next;
            cols_q <= col_drive(col_next);
          end
        end
        DEBOUNCE: begin
          if (!row_pressed) begin
            cnt_q   <= 4'd0;
            state_q <= SCAN;
          end else if (cnt_done) begin
            cnt_q   <= 4'd0;
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HELD: begin
          // HELD counts release ticks; any bounce back to pressed restarts the count.
          if (row_pressed) begin
            cnt_q <= 4'd0;
          end else if (cnt_done) begin
            cnt_q   <= 4'd0;
            state_q <= SCAN;
            col_q   <= col_next;
            cols_q  <= col_drive(col_next);
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  // Ack clears first; a same-cycle accept overrides it and keeps the key valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && key_if.key_ack) valid_q <= 1'b0;
      if (accept) begin
        code_q    <= {accept_row, col_q};
        valid_q   <= 1'b1;
        overrun_q <= valid_q && !key_if.key_ack;
      end
    end
  end

  assign cols_o           = cols_q;
  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_if.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: physical keypad model, key scoreboard and immediate-assertion checks.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_tick = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] pressed = '0;

  int tests = 0;
  int fails = 0;
  int overrun_cnt = 0;
  logic [3:0] sb_q[$];

  keypad_scanner_if kif ();

  keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_tick_i (scan_tick),
    .rows_i      (rows),
    .cols_o      (cols),
    .key_if      (kif)
  );

  initial forever #5 clk = ~clk;
  initial forever #100 scan_tick = ~scan_tick;

  // Switch matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Key monitor: every accept shows as a valid rise, a code change, or an overrun pulse.
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (kif.overrun) overrun_cnt++;
      if (kif.key_valid && (!prev_valid || kif.key_code != prev_code || kif.overrun)) begin
        check("sb_has_entry", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) check("key_code", kif.key_code, sb_q.pop_front());
      end
    end
    prev_valid = kif.key_valid;
    prev_code  = kif.key_code;
  end

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic tick();
    @(posedge scan_tick);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_col(input int c);
    for (int i = 0; i < 8 && cols !== col_pat(c); i++) tick();
    check("wait_col", cols, col_pat(c));
  endtask

  task automatic do_ack();
    @(negedge clk);
    kif.key_ack = 1'b1;
    @(posedge clk);
    #1 kif.key_ack = 1'b0;
    check("valid_after_ack", kif.key_valid, 0);
  endtask

  task automatic release_reset();
    @(negedge scan_tick);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    kif.key_ack = 1'b0;

    // Reset held while inputs wiggle
    pressed = 16'hFFFF;
    #250;
    kif.key_ack = 1'b1;
    #20 kif.key_ack = 1'b0;
    check("rst_cols", cols, 4'b1110);
    check("rst_valid", kif.key_valid, 0);
    check("rst_code", kif.key_code, 0);
    check("rst_overrun", kif.overrun, 0);
    pressed = '0;
    release_reset();

    // Idle scan sequence
    tick(); check("scan1", cols, 4'b1101);
    tick(); check("scan2", cols, 4'b1011);
    tick(); check("scan3", cols, 4'b0111);
    tick(); check("scan4", cols, 4'b1110);
    tick(); check("scan5", cols, 4'b1101);

    // Clean press of key 9 (row 2, col 1), exact latency on the 4th tick
    pressed[9] = 1'b1;
    sb_q.push_back(4'd9);
    ticks(3);
    check("press_not_yet", kif.key_valid, 0);
    check("press_col_held", cols, 4'b1101);
    @(posedge scan_tick);
    repeat (3) @(posedge clk);
    #1 check("valid_before_edge", kif.key_valid, 0);
    @(posedge clk);
    #1 check("valid_on_4th_tick", kif.key_valid, 1);
    check("code9", kif.key_code, 9);
    do_ack();
    ticks(6);
    check("no_repeat", kif.key_valid, 0);
    check("held_col", cols, 4'b1101);
    pressed = '0;
    ticks(3);
    check("release_pending", cols, 4'b1101);
    tick();
    check("release_advance", cols, 4'b1011);

    // Bounce at column 3: two pressed ticks only
    wait_col(3);
    pressed[3] = 1'b1;
    ticks(2);
    pressed = '0;
    tick();
    check("bounce_same_col", cols, 4'b0111);
    tick();
    check("bounce_resume", cols, 4'b1110);
    check("bounce_no_key", kif.key_valid, 0);

    // Release debounce on key 0
    wait_col(0);
    pressed[0] = 1'b1;
    sb_q.push_back(4'd0);
    ticks(4);
    check("key0_valid", kif.key_valid, 1);
    do_ack();
    pressed = '0;
    ticks(2);
    pressed[0] = 1'b1;
    ticks(3);
    check("rebounce_no_key", kif.key_valid, 0);
    check("rebounce_held", cols, 4'b1110);
    pressed = '0;
    ticks(3);
    check("release_cnt_cleared", cols, 4'b1110);
    tick();
    check("release_done", cols, 4'b1101);
    wait_col(0);
    pressed[0] = 1'b1;
    sb_q.push_back(4'd0);
    ticks(4);
    check("key0_again_valid", kif.key_valid, 1);
    check("key0_again_code", kif.key_code, 0);
    do_ack();
    pressed = '0;
    ticks(4);

    // Overrun: key 5 then key 10 without ack
    wait_col(1);
    pressed[5] = 1'b1;
    sb_q.push_back(4'd5);
    ticks(4);
    pressed = '0;
    ticks(4);
    wait_col(2);
    pressed[10] = 1'b1;
    sb_q.push_back(4'd10);
    ticks(4);
    check("overrun_count", overrun_cnt, 1);
    check("overrun_code", kif.key_code, 10);
    check("overrun_valid", kif.key_valid, 1);
    pressed = '0;
    ticks(4);

    // Collision: ack on the accept cycle of key 15
    wait_col(3);
    pressed[15] = 1'b1;
    sb_q.push_back(4'd15);
    ticks(3);
    @(posedge scan_tick);
    repeat (3) @(posedge clk);
    #1 kif.key_ack = 1'b1;
    @(posedge clk);
    #1 kif.key_ack = 1'b0;
    check("collision_valid", kif.key_valid, 1);
    check("collision_code", kif.key_code, 15);
    check("collision_no_overrun", overrun_cnt, 1);
    do_ack();
    pressed = '0;
    ticks(4);

    // Reset in the middle of a debounce
    wait_col(0);
    pressed[4] = 1'b1;
    ticks(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cols", cols, 4'b1110);
    check("midrst_valid", kif.key_valid, 0);
    check("midrst_code", kif.key_code, 0);
    check("midrst_overrun", kif.overrun, 0);
    pressed = '0;
    release_reset();
    ticks(6);
    check("midrst_no_key", kif.key_valid, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
